// File: rtl/pipe_stage_reg_if.sv
// Handshake and observation bundle for pipe_stage_reg: upstream inputs,
// last-stage outputs, EPC capture and the optional perf counters.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 213,
   parameter int PC_W  = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [PC_W-1:0]  in_pc;
   logic             stall;
   logic             flush;
   logic             epc_ack;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [PC_W-1:0]  out_pc;
   logic             busy;
   logic [PC_W-1:0]  epc;
   logic             epc_valid;
   logic [31:0]      stall_cnt;
   logic [31:0]      bubble_cnt;

   modport master (
      output in_valid, in_data, in_pc, stall, flush, epc_ack,
      input  out_valid, out_data, out_pc, busy, epc, epc_valid, stall_cnt, bubble_cnt
   );

   modport slave (
      input  in_valid, in_data, in_pc, stall, flush, epc_ack,
      output out_valid, out_data, out_pc, busy, epc, epc_valid, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with stall/flush, EPC capture on flush and
// optional stall/bubble counters enabled by `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg_slot #(
   parameter int WIDTH = 213,
   parameter int PC_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             d_vld,
   input  logic [WIDTH-1:0] d_data,
   input  logic [PC_W-1:0]  d_pc,
   output logic             q_vld,
   output logic [WIDTH-1:0] q_data,
   output logic [PC_W-1:0]  q_pc
);
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         q_vld  <= 1'b0;
         q_data <= '0;
         q_pc   <= '0;
      end else if (en) begin
         q_vld  <= d_vld;
         q_data <= d_data;
         q_pc   <= d_pc;
      end
   end
endmodule

module pipe_stage_reg #(
   parameter int WIDTH = 213,
   parameter int DEPTH = 1,
   parameter int PC_W  = 32
) (
   input logic            clk,
   input logic            rst_n,
   pipe_stage_reg_if.slave bus
);
   // Index 0 is the gated input; index i+1 is the output of stage i.
   logic [DEPTH:0]            vld_pipe;
   logic [DEPTH:0][WIDTH-1:0] data_pipe;
   logic [DEPTH:0][PC_W-1:0]  pc_pipe;

   assign vld_pipe[0]  = bus.in_valid;
   assign data_pipe[0] = bus.in_valid ? bus.in_data : '0;
   assign pc_pipe[0]   = bus.in_valid ? bus.in_pc : '0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      pipe_stage_reg_slot #(.WIDTH(WIDTH), .PC_W(PC_W)) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (~bus.stall),
         .clr    (bus.flush),
         .d_vld  (vld_pipe[i]),
         .d_data (data_pipe[i]),
         .d_pc   (pc_pipe[i]),
         .q_vld  (vld_pipe[i+1]),
         .q_data (data_pipe[i+1]),
         .q_pc   (pc_pipe[i+1])
      );
   end

   assign bus.out_valid = vld_pipe[DEPTH];
   assign bus.out_data  = data_pipe[DEPTH];
   assign bus.out_pc    = pc_pipe[DEPTH];
   assign bus.busy      = |vld_pipe[DEPTH:1];

   // Oldest valid stage wins; the incoming instruction only if the pipe is empty.
   logic            cap;
   logic [PC_W-1:0] cap_pc;

   always_comb begin
      cap    = 1'b0;
      cap_pc = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         if (vld_pipe[i]) begin
            cap    = 1'b1;
            cap_pc = pc_pipe[i];
         end
      end
      if (!cap && bus.in_valid) begin
         cap    = 1'b1;
         cap_pc = bus.in_pc;
      end
   end

   logic [PC_W-1:0] epc_q;
   logic            epc_vld_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         epc_q     <= '0;
         epc_vld_q <= 1'b0;
      end else if (bus.flush && cap) begin
         epc_q     <= cap_pc;
         epc_vld_q <= 1'b1;
      end else if (bus.epc_ack) begin
         epc_vld_q <= 1'b0;
      end
   end

   assign bus.epc       = epc_q;
   assign bus.epc_valid = epc_vld_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] bubble_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (!bus.flush && bus.stall && stall_q != '1)
            stall_q <= stall_q + 32'd1;
         if ((bus.flush || (!bus.stall && !bus.in_valid)) && bubble_q != '1)
            bubble_q <= bubble_q + 32'd1;
      end
   end

   assign bus.stall_cnt  = stall_q;
   assign bus.bubble_cnt = bubble_q;
`else
   assign bus.stall_cnt  = '0;
   assign bus.bubble_cnt = '0;
`endif
endmodule
